// File: rtl/i2c_bus_pkg.sv
// Shared types and constants for the board-level I2C bus arbiter.
package i2c_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OWN     = 3'd1,
    ST_RECOVER = 3'd2,
    ST_STOP    = 3'd3,
    ST_GAP     = 3'd4
  } arb_state_t;

  // Bus recovery clocks out 9 SCL pulses, one half-period per cycle.
  localparam int unsigned RECOVER_PULSES = 9;
  localparam int unsigned RECOVER_CYC    = 2 * RECOVER_PULSES;

  // STOP sequence: two cycles SDA low with SCL high, then SDA released.
  localparam int unsigned STOP_CYC = 3;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after i_ptr, modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_j;

  // Scan from the pointer, wrapping, and take the first eligible requester.
  always_comb begin
    o_win = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = PW'((32'(i_ptr) + k) % N);
      if (!o_any && i_elig[w_j]) begin
        o_win[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of the shared I2C pins: muxes the granted controller onto
// SCL/SDA, enforces a bus-free gap between owners, and recovers a hung bus
// (9 SCL pulses then STOP) when an owner overstays TIMEOUT cycles.
module i2c_bus_arbiter
  import i2c_bus_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 4095,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic             RESET_N,
  input  logic             CLK_400K,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GNT,
  input  logic [N_REQ-1:0] M_SCL,
  input  logic [N_REQ-1:0] M_SDAO,
  output logic             SDAI,
  output logic             I2C_SCL,
  inout  wire              I2C_SDA,
  output logic             BUSY,
  output logic             TO_ERR,
  output logic [2:0]       ERR_ID
);

  localparam int unsigned PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);
  localparam int unsigned SUB_M1  = (RECOVER_CYC > STOP_CYC) ? RECOVER_CYC : STOP_CYC;
  localparam int unsigned SUB_MAX = (GAP_CYC > SUB_M1) ? GAP_CYC : SUB_M1;
  localparam int unsigned SUB_W   = $clog2(SUB_MAX);

  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PW-1:0]    r_gidx, w_gidx_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [N_REQ-1:0] r_lock, w_lock_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [SUB_W-1:0] r_sub, w_sub_nxt;
  logic             r_to_err, w_to_err_nxt;
  logic [2:0]       r_err_id, w_err_id_nxt;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_win;
  logic [PW-1:0]    w_win_idx;
  logic             w_any;
  logic             w_owner_req;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_scl;
  logic             w_sdao;

  assign w_elig      = REQ & ~r_lock;
  assign w_owner_req = |(REQ & r_gnt);
  assign w_ptr_inc   = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_win  (w_win),
    .o_idx  (w_win_idx),
    .o_any  (w_any)
  );

  // State and bookkeeping registers.
  always_ff @(posedge CLK_400K or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_gidx   <= '0;
      r_ptr    <= '0;
      r_lock   <= '0;
      r_cnt    <= '0;
      r_sub    <= '0;
      r_to_err <= 1'b0;
      r_err_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_gidx   <= w_gidx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_lock   <= w_lock_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sub    <= w_sub_nxt;
      r_to_err <= w_to_err_nxt;
      r_err_id <= w_err_id_nxt;
    end
  end

  // Next-state: grant, release, timeout and the recovery/stop/gap sequencing.
  // An owner may hold the bus for at most TIMEOUT cycles; release beats timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gidx_nxt   = r_gidx;
    w_ptr_nxt    = r_ptr;
    w_lock_nxt   = r_lock & REQ;
    w_cnt_nxt    = r_cnt;
    w_sub_nxt    = r_sub;
    w_to_err_nxt = 1'b0;
    w_err_id_nxt = r_err_id;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_sub_nxt = '0;
        if (w_any) begin
          w_gnt_nxt   = w_win;
          w_gidx_nxt  = w_win_idx;
          w_state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!w_owner_req) begin
          w_gnt_nxt   = '0;
          w_ptr_nxt   = w_ptr_inc;
          w_sub_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_gnt_nxt    = '0;
          w_to_err_nxt = 1'b1;
          w_err_id_nxt = 3'(r_gidx);
          w_lock_nxt   = (r_lock & REQ) | r_gnt;
          w_ptr_nxt    = w_ptr_inc;
          w_sub_nxt    = '0;
          w_state_nxt  = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (r_sub == SUB_W'(RECOVER_CYC - 1)) begin
          w_sub_nxt   = '0;
          w_state_nxt = ST_STOP;
        end else begin
          w_sub_nxt = r_sub + SUB_W'(1);
        end
      end
      ST_STOP: begin
        if (r_sub == SUB_W'(STOP_CYC - 1)) begin
          w_sub_nxt   = '0;
          w_state_nxt = ST_GAP;
        end else begin
          w_sub_nxt = r_sub + SUB_W'(1);
        end
      end
      ST_GAP: begin
        if (r_sub == SUB_W'(GAP_CYC - 1)) begin
          w_sub_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_sub_nxt = r_sub + SUB_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // Pin mux: only the granted controller reaches the bus; reset releases it at once.
  always_comb begin
    w_scl  = 1'b1;
    w_sdao = 1'b1;
    case (r_state)
      ST_OWN: begin
        w_scl  = &(M_SCL | ~r_gnt);
        w_sdao = &(M_SDAO | ~r_gnt);
      end
      ST_RECOVER: w_scl  = r_sub[0];
      ST_STOP:    w_sdao = (r_sub == SUB_W'(STOP_CYC - 1));
      default:    ;
    endcase
  end

  assign I2C_SCL = w_scl;
  assign I2C_SDA = w_sdao ? 1'bz : 1'b0;
  assign SDAI    = I2C_SDA;
  assign GNT     = r_gnt;
  assign BUSY    = (r_state != ST_IDLE);
  assign TO_ERR  = r_to_err;
  assign ERR_ID  = r_err_id;

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one physical I2C bus (I2C_SCL / I2C_SDA) among up to N_REQ independent sensor controllers.
- Each controller is a full sequencer built on the write-pointer / write-word / read engines, and each drives its own SCL and open-drain SDA enables.
- Grants are round-robin. The block enforces a bus-free gap between owners and recovers a hung bus on owner timeout (9 SCL pulses, then STOP).
- Sits at the board-level I2C pin, between the sensor controllers and the pads.

Parameters:
- N_REQ, 4: number of requesters, 1..8.
- TIMEOUT, 4095: maximum CLK_400K cycles one owner may hold the bus. Counter width is clog2(TIMEOUT+1).
- GAP_CYC, 4: bus-free cycles inserted after every release or recovery, minimum 1.

Ports:
- RESET_N, in, 1: asynchronous, active-low reset.
- CLK_400K, in, 1: arbiter clock, same clock as the I2C engines.
- REQ, in, N_REQ: request per controller. Held high for the whole transaction; dropped to release the bus.
- GNT, out, N_REQ: one-hot grant, registered.
- M_SCL, in, N_REQ: per-requester SCL (1 = release).
- M_SDAO, in, N_REQ: per-requester SDA enable (1 = release, 0 = pull low).
- SDAI, out, 1: sampled I2C_SDA, fanned out to all requesters.
- I2C_SCL, out, 1: bus clock.
- I2C_SDA, inout, 1: open-drain; driven 0 when internal SDAO = 0, otherwise z.
- BUSY, out, 1: high in any state except IDLE.
- TO_ERR, out, 1: one-cycle pulse when a timeout fires.
- ERR_ID, out, 3: index of the requester that timed out; held until the next timeout.

Behaviour:
- Reset values: GNT=0, BUSY=0, TO_ERR=0, ERR_ID=0, I2C_SCL=1, SDA released, round-robin pointer PTR=0, all lockout bits clear, state IDLE.
- Bus mux:
  - OWN: I2C_SCL = M_SCL[g]; SDAO = M_SDAO[g].
  - Non-granted requester lines are ignored (treated as 1) in every state.
  - GAP: SCL=1, SDAO=1.
  - RECOVER / STOP: the arbiter drives the bus itself.
- Eligibility: eligible = REQ & ~LOCK.
- Winner: the first eligible index at or after PTR, scanning modulo N_REQ.
- State IDLE:
  - If any requester is eligible, GNT[winner] is set at the next edge and the state moves to OWN.
  - Grant latency is 1 cycle from REQ seen high.
  - Timeout counter is cleared.
- State OWN (owner g):
  - Timeout counter increments every cycle.
  - If REQ[g]=0: at the same edge GNT=0, PTR=g+1 (wraps to 0 at N_REQ), state moves to GAP.
  - Else if the counter reaches TIMEOUT: GNT=0, TO_ERR=1 for one cycle, ERR_ID=g, LOCK[g]=1, PTR=g+1, state moves to RECOVER.
  - If both conditions hold in the same cycle, the release wins and no error is flagged.
- State RECOVER:
  - SDA released. SCL toggles every cycle, starting low, for 18 cycles (9 pulses), then SCL=1.
  - State moves to STOP.
- State STOP: three cycles.
  - Cycle 1: SCL=1, SDA=0.
  - Cycle 2: SCL=1, SDA=0.
  - Cycle 3: SDA released.
  - Then state moves to GAP.
- State GAP:
  - Bus idle for exactly GAP_CYC cycles, then IDLE.
  - Requests arriving during GAP are held and evaluated in IDLE.
- Lockout: LOCK[i] clears on any cycle where REQ[i]=0. A timed-out requester is never regranted until it has dropped REQ at least one cycle.
- Owner dropping REQ for exactly one cycle counts as a release. Re-raising REQ joins normal round-robin arbitration.
- Reset mid-operation:
  - Immediate return to reset values.
  - Bus released asynchronously (SCL=1, SDA=z) without a STOP.
- SDAI = I2C_SDA, combinational, to all requesters.

Decomposition:
- Shared package i2c_bus_pkg holds:
  - State encoding (IDLE, OWN, RECOVER, STOP, GAP).
  - RECOVER_PULSES=9.
  - STOP_CYC=3.
- Sub-module rr_pick: combinational round-robin priority picker (eligible vector, PTR in; one-hot winner and index out).

Test Plan:
1. Single requester:
   - Stimulus: REQ=0001, toggle M_SCL/M_SDAO, drop REQ after 40 cycles.
   - Required: GNT=0001 one cycle after REQ; bus follows requester 0; GNT=0 same edge REQ falls; BUSY high through GAP (4 cycles); back to IDLE.
2. Simultaneous requests, PTR=0:
   - Stimulus: REQ=0110.
   - Required: requester 1 granted first; on its release, requester 2 granted after the 4-cycle GAP; PTR=3 afterwards.
3. Masking:
   - Stimulus: requester 0 owns the bus; requester 3 drives M_SCL=0, M_SDAO=0.
   - Required: I2C_SCL and I2C_SDA unaffected by requester 3.
4. Timeout:
   - Stimulus: TIMEOUT=20; requester 2 holds REQ.
   - Required: TO_ERR pulse at count 20, ERR_ID=2; exactly 9 SCL low pulses with SDA=z; STOP (SDA low while SCL high, then released); GAP; requester 2 not regranted until REQ drops for one cycle.
5. Release and timeout in the same cycle:
   - Stimulus: REQ[g] falls on the cycle the counter reaches TIMEOUT.
   - Required: no TO_ERR; state goes straight to GAP.
6. Reset mid-RECOVER:
   - Stimulus: assert RESET_N=0 at recovery pulse 4.
   - Required: I2C_SCL=1, SDA=z, GNT=0, PTR=0 immediately; after release, REQ=1000 grants requester 3 one cycle later.
